// File: rtl/call_ret_ctrl_pkg.sv
// Shared types and constants for the CALL/RET sequencer and its return stack.
package call_ret_ctrl_pkg;

    localparam int unsigned WORD_W          = 32;
    localparam int unsigned STACK_DEPTH_MAX = 15;
    localparam int unsigned DEPTH_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2,
        CAPT = 2'd3
    } state_e;

endpackage

// File: rtl/call_ret_ctrl_if.sv
// Decoder/fetch/stack-facing signal bundle for call_ret_ctrl.
interface call_ret_ctrl_if
    import call_ret_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W
);

    logic                call_req;
    logic                ret_req;
    logic [DATA_W-1:0]   pc_cur;
    logic [DATA_W-1:0]   call_target;
    logic                stk_push_en;
    logic                stk_pop_en;
    logic [DATA_W-1:0]   stk_data_in;
    logic [DATA_W-1:0]   stk_data_out;
    logic                redirect_valid;
    logic [DATA_W-1:0]   redirect_pc;
    logic                stall;
    logic [DEPTH_W-1:0]  depth;
    logic                ovf_err;
    logic                unf_err;

    modport slave (
        input  call_req, ret_req, pc_cur, call_target, stk_data_out,
        output stk_push_en, stk_pop_en, stk_data_in, redirect_valid,
               redirect_pc, stall, depth, ovf_err, unf_err
    );

    modport master (
        output call_req, ret_req, pc_cur, call_target, stk_data_out,
        input  stk_push_en, stk_pop_en, stk_data_in, redirect_valid,
               redirect_pc, stall, depth, ovf_err, unf_err
    );

endinterface

// File: rtl/call_ret_ctrl.sv
// Sequences CALL/RET into return-stack push/pop strobes, PC redirects and a
// shadow depth count with overflow/underflow error pulses.
module call_ret_ctrl
    import call_ret_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W    = WORD_W,
    parameter int unsigned DEPTH_MAX = STACK_DEPTH_MAX,
    parameter int unsigned PC_INC    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    call_ret_ctrl_if.slave  bus
);

    state_e              state_q, state_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                push_q, push_d;
    logic                pop_q, pop_d;
    logic                rv_q, rv_d;
    logic [DATA_W-1:0]   rpc_q, rpc_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            depth_q <= '0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
            din_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
            din_q   <= din_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        rv_d    = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        rpc_d   = rpc_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (bus.call_req && bus.ret_req) begin
                    ovf_d = 1'b1;
                    unf_d = 1'b1;
                end else if (bus.call_req) begin
                    if (depth_q == DEPTH_W'(DEPTH_MAX)) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_d  = 1'b1;
                        din_d   = bus.pc_cur + DATA_W'(PC_INC);
                        rpc_d   = bus.call_target;
                        rv_d    = 1'b1;
                        depth_d = depth_q + 1'b1;
                        state_d = PUSH;
                    end
                end else if (bus.ret_req) begin
                    if (depth_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        pop_d   = 1'b1;
                        depth_d = depth_q - 1'b1;
                        state_d = POP;
                    end
                end
            end
            PUSH: state_d = IDLE;
            // The stack loads data_out on the edge leaving POP; capture it one edge later.
            POP:  state_d = CAPT;
            CAPT: begin
                rpc_d   = bus.stk_data_out;
                rv_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.stk_push_en    = push_q;
    assign bus.stk_pop_en     = pop_q;
    assign bus.stk_data_in    = din_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;
    assign bus.depth          = depth_q;
    assign bus.ovf_err        = ovf_q;
    assign bus.unf_err        = unf_q;
    assign bus.stall          = (state_q != IDLE);

endmodule
